// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART receiver and transmitter so that both ends
//   of the link agree on frame shape and default bit timing.
//   - rx_state_e          : receiver FSM state encoding
//   - DATA_BITS           : data bits per frame (8N1)
//   - IDX_WIDTH           : width of a data-bit index
//   - CLKS_PER_BIT_DEFAULT: clk cycles per bit at 12 MHz / 9600 baud
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int IDX_WIDTH            = $clog2(DATA_BITS);
  localparam int CLKS_PER_BIT_DEFAULT = 1250;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage : uart_pkg

// File: rtl/sync2ff.sv
// ----------------------------------------------------------------------------
// sync2ff
//   Two-flop synchroniser for a single asynchronous input. The reset value is
//   chosen per use so the synchronised signal starts at its idle level.
//   Ports:
//     clk  in  system clock
//     rstn in  synchronous reset, active low
//     d    in  asynchronous input
//     q    out synchronised copy of d (two clk of latency)
// ----------------------------------------------------------------------------
module sync2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : sync2ff

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver. Samples each bit at its middle, assembles the byte LSB
//   first and hands it over through a valid/ack holding register. Framing
//   errors and overruns are reported through sticky flags.
//   Ports:
//     clk       in  system clock
//     rstn      in  synchronous reset, active low
//     rx        in  asynchronous serial input, idle high
//     rx_ack    in  consumer has taken rx_byte; clears rx_valid
//     err_clr   in  clears frame_err and overrun
//     rx_byte   out last received byte
//     rx_valid  out rx_byte holds an unconsumed byte
//     frame_err out sticky: stop bit sampled low
//     overrun   out sticky: byte completed while rx_valid was still set
//     busy      out high whenever the receiver is not idle
// ----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  input  logic       rx_ack,
  input  logic       err_clr,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_HALF = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(DATA_BITS - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);

  logic rx_s;

  rx_state_e                state_d, state_q;
  logic [CNT_WIDTH-1:0]     cnt_d, cnt_q;
  logic [IDX_WIDTH-1:0]     idx_d, idx_q;
  logic [DATA_BITS-1:0]     shift_d, shift_q;
  logic [7:0]               rx_byte_d, rx_byte_q;
  logic                     rx_valid_d, rx_valid_q;
  logic                     frame_err_d, frame_err_q;
  logic                     overrun_d, overrun_q;

  logic expired;
  logic commit;
  logic frame_bad;

  // Synchronise rx; its reset value of 1 keeps the line idle out of reset.
  sync2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx),
    .q    (rx_s)
  );

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic: bit timing, deserialisation and the holding register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    commit      = 1'b0;
    frame_bad   = 1'b0;
    expired     = (cnt_q == '0);

    case (state_q)
      ST_IDLE: begin
        // Half a bit period lands the next sample in the middle of the start bit.
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = CNT_HALF;
        end
      end
      ST_START: begin
        if (!expired) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
          idx_d   = '0;
          cnt_d   = CNT_FULL;
        end
      end
      ST_DATA: begin
        if (!expired) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_d[idx_q] = rx_s;
          cnt_d          = CNT_FULL;
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      ST_STOP: begin
        if (!expired) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          frame_bad = 1'b1;
          state_d   = ST_BREAK;
        end
      end
      ST_BREAK: begin
        // Stay here while the line is held low so a break raises one error only.
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An ack coinciding with a commit means the old byte was taken, so the new
    // one replaces it without an overrun.
    if (commit) begin
      if (!rx_valid_q || rx_ack) begin
        rx_byte_d  = shift_q;
        rx_valid_d = 1'b1;
      end
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
    end

    // Clear first so that a same-cycle set wins.
    if (err_clr) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (frame_bad) begin
      frame_err_d = 1'b1;
    end
    if (commit && rx_valid_q && !rx_ack) begin
      overrun_d = 1'b1;
    end
  end

  // Outputs.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    rx_byte   = rx_byte_q;
    rx_valid  = rx_valid_q;
    frame_err = frame_err_q;
    overrun   = overrun_q;
  end

endmodule : uart_rx

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the CPU's UART transmitter.
- Deserialises the async rx pin into bytes and presents them through a valid/ack holding register.
- Feeds a future IN instruction, which polls rx_valid and loads rx_byte into register A.
- Sticky error flags for framing errors and overruns.

Parameters:
CLKS_PER_BIT, 1250, clk cycles per bit (12 MHz / 9600 baud); must be >= 8
CNT_WIDTH, $clog2(CLKS_PER_BIT), width of the bit-period counter

Ports:
clk  in  1  system clock
rstn  in  1  synchronous reset, active low
rx  in  1  asynchronous serial input, idle high
rx_ack  in  1  consumer has taken rx_byte; clears rx_valid
err_clr  in  1  clears frame_err and overrun
rx_byte  out  8  last received byte, LSB first on the wire
rx_valid  out  1  rx_byte holds an unconsumed byte
frame_err  out  1  sticky: stop bit sampled low
overrun  out  1  sticky: byte completed while rx_valid was still set
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rstn=0 at a clk edge):
  - rx_byte=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - State=IDLE, counters=0, synchroniser flops=1.
  - Reset mid-frame aborts the frame with no output change except the clears above.
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s only.
- IDLE:
  - rx_s==0 -> START, bit counter loaded with CLKS_PER_BIT/2-1.
- START:
  - On expiry, sample rx_s (mid start bit).
  - 1 -> false start, back to IDLE, no flags.
  - 0 -> DATA, bit index=0, counter=CLKS_PER_BIT-1.
- DATA:
  - On each expiry, shift rx_s into the shift register at bit[index] (LSB first) and reload the counter.
  - After index 7 -> STOP.
- STOP, on expiry, sample rx_s:
  - 1 -> commit (see below) -> IDLE.
  - 0 -> frame_err<=1, byte discarded -> BREAK.
- BREAK: wait until rx_s==1, then IDLE. A held-low line produces exactly one frame_err.
- Commit rules, applied in the cycle after the stop sample:
  - rx_valid==0: rx_byte<=shift, rx_valid<=1.
  - rx_valid==1 and rx_ack==1 the same cycle: rx_byte<=shift, rx_valid stays 1, no overrun.
  - rx_valid==1 and rx_ack==0: overrun<=1, new byte dropped, old rx_byte kept.
- rx_ack when no commit is occurring: rx_valid<=0. rx_ack while rx_valid==0 is ignored.
- err_clr clears both flags. If a flag event occurs in the same cycle, the set wins.
- Latency: rx_valid rises 9.5*CLKS_PER_BIT + 3 clk (±1) after the rx pin falls. The bench checks within ±2 clk.
- Back-to-back frames: a start bit immediately after the stop sample is accepted, so there is no lost frame at 0 idle bits.
- Tolerates ±4% baud mismatch by mid-bit sampling; no oversampling vote.

Decomposition:
- Shared package (uart_pkg):
  - State encoding IDLE/START/DATA/STOP/BREAK.
  - DATA_BITS=8.
  - Default CLKS_PER_BIT, shared with the UART transmitter so both ends agree.
- One sub-module: sync2ff (parameter RESET_VAL=1), a 2-flop synchroniser, reused for any future async input.
- Counter and FSM stay in uart_rx.

Test Plan:
- CLKS_PER_BIT=16, send 0xA5 with one stop bit -> rx_valid=1 at 155±2 clk after the edge, rx_byte=0xA5, frame_err=0, overrun=0.
- Send 0x3C then 0xC3 back-to-back with no ack -> rx_byte=0x3C, rx_valid=1, overrun=1. Then pulse err_clr -> overrun=0.
- Send 0x3C, ack in the exact cycle 0xC3 commits -> rx_byte=0xC3, rx_valid=1, overrun=0.
- 0.25-bit low glitch (4 clk) on idle rx -> stays/returns IDLE, rx_valid=0, no flags, busy high ≤9 clk.
- Frame 0x55 with stop bit forced 0, line held low 3 bit times -> frame_err=1 once, rx_valid=0, BREAK until rx high, then 0x81 received correctly.
- rstn pulled low mid-DATA of 0xFF -> all outputs 0. The next full frame 0x12 is received as 0x12.
